// File: rtl/qtree_int_serializer_pkg.sv
// Shared QTree_Int heap/stream types, tag constants, the traversal frame
// and word helpers used by the serializer and its frame stack.
package mMaskKron_package;

    typedef logic [31:0] Int_t;
    typedef logic [16:0] Pointer_QTree_Int_t;
    typedef logic [66:0] QTree_Int_t;

    localparam logic [1:0] TAG_QNONE  = 2'd0;
    localparam logic [1:0] TAG_QVAL   = 2'd1;
    localparam logic [1:0] TAG_QNODE  = 2'd2;
    localparam logic [1:0] TAG_QERROR = 2'd3;

    localparam QTree_Int_t         QNode_Int_dc         = 67'd0;
    localparam Pointer_QTree_Int_t Pointer_QTree_Int_dc = 17'd0;
    localparam QTree_Int_t         QERROR_WORD          = {64'd0, TAG_QERROR, 1'b1};

    typedef struct packed {
        QTree_Int_t word;
        logic [2:0] idx;
    } qtree_frame_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_NEXT  = 3'd3,
        S_EMIT  = 3'd4
    } ser_state_e;

    function automatic QTree_Int_t QTree_Int_node_strip(input QTree_Int_t w);
        QTree_Int_t r;
        r = w;
        r[66:3] = 64'd0;
        return r;
    endfunction

    function automatic logic [15:0] qtree_child_addr(input QTree_Int_t w, input logic [2:0] idx);
        logic [15:0] a;
        case (idx)
            3'd0:    a = w[18:3];
            3'd1:    a = w[34:19];
            3'd2:    a = w[50:35];
            default: a = w[66:51];
        endcase
        return a;
    endfunction

endpackage

// File: rtl/qtree_int_frame_stack.sv
// Synchronous LIFO of traversal frames; the top frame's child index can be
// rewritten in place while the node's children are being visited.
module qtree_int_frame_stack
    import mMaskKron_package::*;
#(
    parameter int DEPTH = 16,
    localparam int SPW = $clog2(DEPTH + 1),
    localparam int IW  = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         aresetn,
    input  logic         push_i,
    input  qtree_frame_t push_frame_i,
    input  logic         pop_i,
    input  logic         upd_i,
    input  logic [2:0]   upd_idx_i,
    output qtree_frame_t top_o,
    output logic [SPW-1:0] sp_o,
    output logic         full_o,
    output logic         empty_o
);
    qtree_frame_t   mem_q [DEPTH];
    logic [SPW-1:0] sp_q;
    logic [IW-1:0]  wr_idx_s;
    logic [IW-1:0]  top_idx_s;

    assign wr_idx_s  = IW'(sp_q);
    assign top_idx_s = IW'(sp_q - SPW'(1));
    assign full_o    = (sp_q == SPW'(DEPTH));
    assign empty_o   = (sp_q == SPW'(0));
    assign sp_o      = sp_q;
    assign top_o     = mem_q[top_idx_s];

    // stack pointer
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            sp_q <= SPW'(0);
        end else if (push_i && !full_o) begin
            sp_q <= sp_q + SPW'(1);
        end else if (pop_i && !empty_o) begin
            sp_q <= sp_q - SPW'(1);
        end
    end

    // frame storage needs no reset: sp alone defines which frames are live
    always_ff @(posedge clk) begin
        if (push_i && !full_o) begin
            mem_q[wr_idx_s] <= push_frame_i;
        end else if (upd_i && !empty_o) begin
            mem_q[top_idx_s].idx <= upd_idx_i;
        end
    end

endmodule

// File: rtl/qtree_int_serializer.sv
// Depth-first postfix walk of a QTree_Int heap structure, emitting one
// AXI-stream word per node (children first) with tlast on the root word.
module qtree_int_serializer
    import mMaskKron_package::*;
#(
    parameter int STACK_DEPTH = 16
) (
    input  logic               clk,
    input  logic               aresetn,
    input  Pointer_QTree_Int_t root_d,
    output logic               root_r,
    output Pointer_QTree_Int_t rd_req_d,
    input  logic               rd_req_r,
    input  QTree_Int_t         rd_resp_d,
    output logic               rd_resp_r,
    output QTree_Int_t         o_QTree_Int_tdata,
    output logic               o_QTree_Int_tvalid,
    input  logic               o_QTree_Int_tready,
    output logic               o_QTree_Int_tlast,
    output logic               overflow
);
    localparam int SPW = $clog2(STACK_DEPTH + 1);

    ser_state_e         state_q, state_d;
    logic [15:0]        addr_q, addr_d;
    QTree_Int_t         tdata_q, tdata_d;
    logic               tlast_q, tlast_d;
    logic               tvalid_q, tvalid_d;
    logic               overflow_q, overflow_d;
    logic               root_rdy_q, root_rdy_d;
    logic               resp_rdy_q, resp_rdy_d;
    Pointer_QTree_Int_t req_q, req_d;

    logic               push_s, pop_s, upd_s, full_s, empty_s;
    logic [2:0]         upd_idx_s;
    qtree_frame_t       push_frame_s, top_s;
    logic [SPW-1:0]     sp_s;

    qtree_int_frame_stack #(.DEPTH(STACK_DEPTH)) u_stack (
        .clk          (clk),
        .aresetn      (aresetn),
        .push_i       (push_s),
        .push_frame_i (push_frame_s),
        .pop_i        (pop_s),
        .upd_i        (upd_s),
        .upd_idx_i    (upd_idx_s),
        .top_o        (top_s),
        .sp_o         (sp_s),
        .full_o       (full_s),
        .empty_o      (empty_s)
    );

    // state and registered outputs
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q    <= S_IDLE;
            addr_q     <= 16'd0;
            tdata_q    <= 67'd0;
            tlast_q    <= 1'b0;
            tvalid_q   <= 1'b0;
            overflow_q <= 1'b0;
            root_rdy_q <= 1'b0;
            resp_rdy_q <= 1'b0;
            req_q      <= 17'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            tdata_q    <= tdata_d;
            tlast_q    <= tlast_d;
            tvalid_q   <= tvalid_d;
            overflow_q <= overflow_d;
            root_rdy_q <= root_rdy_d;
            resp_rdy_q <= resp_rdy_d;
            req_q      <= req_d;
        end
    end

    // traversal next-state and stack control
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        tdata_d      = tdata_q;
        tlast_d      = tlast_q;
        overflow_d   = overflow_q;
        push_s       = 1'b0;
        pop_s        = 1'b0;
        upd_s        = 1'b0;
        upd_idx_s    = 3'd0;
        push_frame_s = '{word: rd_resp_d, idx: 3'd0};
        case (state_q)
            S_IDLE: begin
                if (root_rdy_q && root_d[0]) begin
                    addr_d  = root_d[16:1];
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                if (rd_req_r) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_WAIT: begin
                if (!rd_resp_d[0]) begin
                    state_d = S_WAIT;
                end else if (rd_resp_d[2:1] != TAG_QNODE) begin
                    tdata_d = rd_resp_d;
                    tlast_d = empty_s;
                    state_d = S_EMIT;
                end else if (full_s) begin
                    // too deep: the subtree is summarised by one QError word
                    tdata_d    = QERROR_WORD;
                    tlast_d    = empty_s;
                    overflow_d = 1'b1;
                    state_d    = S_EMIT;
                end else begin
                    push_s  = 1'b1;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (top_s.idx < 3'd4) begin
                    addr_d    = qtree_child_addr(top_s.word, top_s.idx);
                    upd_s     = 1'b1;
                    upd_idx_s = top_s.idx + 3'd1;
                    state_d   = S_FETCH;
                end else begin
                    tdata_d = QTree_Int_node_strip(top_s.word);
                    tlast_d = (sp_s == SPW'(1));
                    pop_s   = 1'b1;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (tvalid_q && o_QTree_Int_tready) begin
                    state_d = tlast_q ? S_IDLE : S_NEXT;
                end else begin
                    state_d = S_EMIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // outputs follow the state being entered so they are valid from its first cycle
    always_comb begin
        root_rdy_d = (state_d == S_IDLE);
        resp_rdy_d = (state_d == S_WAIT);
        tvalid_d   = (state_d == S_EMIT);
        if (state_d == S_FETCH) begin
            req_d = {addr_d, 1'b1};
        end else begin
            req_d = Pointer_QTree_Int_dc;
        end
    end

    assign root_r             = root_rdy_q;
    assign rd_req_d           = req_q;
    assign rd_resp_r          = resp_rdy_q;
    assign o_QTree_Int_tdata  = tdata_q;
    assign o_QTree_Int_tvalid = tvalid_q;
    assign o_QTree_Int_tlast  = tlast_q;
    assign overflow           = overflow_q;

endmodule

// File: tb/tb_qtree_int_serializer.sv
// Bench for qtree_int_serializer: random heap latency/backpressure against a
// work-list postfix model of the tree held in a bench-side heap array.
module tb_qtree_int_serializer;
    import mMaskKron_package::*;

    typedef struct packed {
        QTree_Int_t d;
        logic       l;
    } exp_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  depth;
        logic        emit;
    } wk_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic aresetn_a, root_r_a, req_r_a, resp_r_a, tvalid_a, tready_a, tlast_a, ovf_a;
    logic aresetn_b, root_r_b, req_r_b, resp_r_b, tvalid_b, tready_b, tlast_b, ovf_b;
    Pointer_QTree_Int_t root_a, req_a, root_b, req_b;
    QTree_Int_t resp_a, tdata_a, resp_b, tdata_b;

    QTree_Int_t heap [0:255];
    exp_t exp_a[$];
    exp_t exp_b[$];
    exp_t mq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   model_ovf;
    bit   tmode_a, rnd_a, tmode_b, rnd_b;

    qtree_int_serializer #(.STACK_DEPTH(16)) dut_a (
        .clk(clk), .aresetn(aresetn_a), .root_d(root_a), .root_r(root_r_a),
        .rd_req_d(req_a), .rd_req_r(req_r_a), .rd_resp_d(resp_a), .rd_resp_r(resp_r_a),
        .o_QTree_Int_tdata(tdata_a), .o_QTree_Int_tvalid(tvalid_a),
        .o_QTree_Int_tready(tready_a), .o_QTree_Int_tlast(tlast_a), .overflow(ovf_a)
    );

    qtree_int_serializer #(.STACK_DEPTH(2)) dut_b (
        .clk(clk), .aresetn(aresetn_b), .root_d(root_b), .root_r(root_r_b),
        .rd_req_d(req_b), .rd_req_r(req_r_b), .rd_resp_d(resp_b), .rd_resp_r(resp_r_b),
        .o_QTree_Int_tdata(tdata_b), .o_QTree_Int_tvalid(tvalid_b),
        .o_QTree_Int_tready(tready_b), .o_QTree_Int_tlast(tlast_b), .overflow(ovf_b)
    );

    task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic QTree_Int_t mk_val(input logic [31:0] v);
        return {32'd0, v, TAG_QVAL, 1'b1};
    endfunction

    function automatic QTree_Int_t mk_leaf(input logic [1:0] tag, input logic [63:0] p);
        return {p, tag, 1'b1};
    endfunction

    function automatic QTree_Int_t mk_node(input logic [15:0] a1, input logic [15:0] a2,
                                           input logic [15:0] a3, input logic [15:0] a4);
        return {a4, a3, a2, a1, TAG_QNODE, 1'b1};
    endfunction

    // Reference: explicit work list, children pushed q4..q1 so q1 is expanded first.
    task automatic model_tree(input int root, input int sd);
        wk_t ws[$];
        wk_t it, c;
        QTree_Int_t w;
        exp_t e;
        it.addr = root[15:0]; it.depth = 8'd1; it.emit = 1'b0;
        ws.push_back(it);
        while (ws.size() > 0) begin
            it = ws.pop_back();
            w = heap[it.addr];
            w[0] = 1'b1;
            e.l = (it.depth == 8'd1);
            if (it.emit) begin
                e.d = w & 67'h7;
                mq.push_back(e);
            end else if (w[2:1] == 2'd2 && int'(it.depth) > sd) begin
                e.d = 67'h7;
                mq.push_back(e);
                model_ovf = 1'b1;
            end else if (w[2:1] == 2'd2) begin
                it.emit = 1'b1;
                ws.push_back(it);
                for (int k = 3; k >= 0; k--) begin
                    c.addr = w[3 + 16*k +: 16];
                    c.depth = it.depth + 8'd1;
                    c.emit = 1'b0;
                    ws.push_back(c);
                end
            end else begin
                e.d = w;
                mq.push_back(e);
            end
        end
    endtask

    task automatic expect_tree(input bit which, input int root, input int sd);
        mq.delete();
        model_tree(root, sd);
        foreach (mq[i]) begin
            if (which) exp_b.push_back(mq[i]);
            else exp_a.push_back(mq[i]);
        end
    endtask

    task automatic send_root(input bit which, input int addr);
        int g;
        g = 0;
        if (which) root_b = {addr[15:0], 1'b1};
        else root_a = {addr[15:0], 1'b1};
        while (((which && !root_r_b) || (!which && !root_r_a)) && g < 3000) begin
            @(posedge clk); #2;
            g++;
        end
        if (g >= 3000) begin
            n_cmp++; n_bad++;
            $display("FAIL root_accept_timeout: got no root_r expected root_r within 3000 cycles");
        end
        @(posedge clk); #2;
        if (which) root_b = 17'd0;
        else root_a = 17'd0;
    endtask

    task automatic wait_done(input bit which);
        int g;
        g = 0;
        while (((which && exp_b.size() > 0) || (!which && exp_a.size() > 0)) && g < 4000) begin
            @(posedge clk); #2;
            g++;
        end
        check("stream_drained", which ? exp_b.size() : exp_a.size(), 67'd0);
        repeat (2) @(posedge clk);
        #2;
    endtask

    // Heap model: one outstanding request, response 0..3 cycles after the handshake.
    task automatic heap_step(input logic rst_n, input Pointer_QTree_Int_t req, input logic resp_rdy,
                             input bit rnd, inout int st, inout int lat, inout logic [15:0] addr,
                             inout logic req_r, inout QTree_Int_t resp);
        if (!rst_n) begin
            st = 0; req_r = 1'b0; resp = 67'd0;
        end else begin
            if (st == 3) begin
                st = 0; resp = 67'd0;
            end
            case (st)
                0: begin
                    req_r = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
                    if (req[0] && req_r) begin
                        addr = req[16:1];
                        lat = rnd ? int'($urandom_range(0, 3)) : 0;
                        st = 1;
                    end
                end
                1: begin
                    req_r = 1'b0;
                    if (lat == 0) begin
                        resp = heap[addr];
                        st = resp_rdy ? 3 : 2;
                    end else begin
                        lat--;
                    end
                end
                2: begin
                    if (resp_rdy) st = 3;
                end
                default: st = 0;
            endcase
        end
    endtask

    initial begin : mon_a
        int st, lat;
        logic [15:0] haddr;
        logic stall, pl;
        QTree_Int_t pd;
        exp_t e;
        st = 0; lat = 0; haddr = 16'd0; stall = 1'b0; pl = 1'b0; pd = 67'd0;
        forever begin
            @(negedge clk);
            heap_step(aresetn_a, req_a, resp_r_a, rnd_a, st, lat, haddr, req_r_a, resp_a);
            if (!aresetn_a) begin
                tready_a = 1'b0; stall = 1'b0; exp_a.delete();
            end else begin
                tready_a = tmode_a ? ~tready_a : 1'b1;
                if (stall) begin
                    check("a_stall_tvalid", tvalid_a, 67'd1);
                    check("a_stall_tdata", tdata_a, pd);
                    check("a_stall_tlast", tlast_a, pl);
                end
                if (tvalid_a && tready_a) begin
                    if (exp_a.size() == 0) begin
                        check("a_unexpected_word", tdata_a, 67'd0);
                        n_bad += (tdata_a == 67'd0) ? 1 : 0;
                    end else begin
                        e = exp_a.pop_front();
                        check("a_tdata", tdata_a, e.d);
                        check("a_tlast", tlast_a, e.l);
                    end
                end
                stall = tvalid_a && !tready_a; pd = tdata_a; pl = tlast_a;
            end
        end
    end

    initial begin : mon_b
        int st, lat;
        logic [15:0] haddr;
        logic stall, pl;
        QTree_Int_t pd;
        exp_t e;
        st = 0; lat = 0; haddr = 16'd0; stall = 1'b0; pl = 1'b0; pd = 67'd0;
        forever begin
            @(negedge clk);
            heap_step(aresetn_b, req_b, resp_r_b, rnd_b, st, lat, haddr, req_r_b, resp_b);
            if (!aresetn_b) begin
                tready_b = 1'b0; stall = 1'b0; exp_b.delete();
            end else begin
                tready_b = tmode_b ? ~tready_b : 1'b1;
                if (stall) begin
                    check("b_stall_tvalid", tvalid_b, 67'd1);
                    check("b_stall_tdata", tdata_b, pd);
                    check("b_stall_tlast", tlast_b, pl);
                end
                if (tvalid_b && tready_b) begin
                    if (exp_b.size() == 0) begin
                        check("b_unexpected_word", tdata_b, 67'd0);
                        n_bad += (tdata_b == 67'd0) ? 1 : 0;
                    end else begin
                        e = exp_b.pop_front();
                        check("b_tdata", tdata_b, e.d);
                        check("b_tlast", tlast_b, e.l);
                    end
                end
                stall = tvalid_b && !tready_b; pd = tdata_b; pl = tlast_b;
            end
        end
    end

    task automatic build_random_tree(input int base);
        logic [1:0] tag;
        int r;
        heap[base] = mk_node(16'(base + 1), 16'(base + 2), 16'(base + 3), 16'(base + 4));
        for (int i = 0; i < 4; i++) begin
            if (i == 0 || $urandom_range(0, 1) == 1) begin
                heap[base + 1 + i] = mk_node(16'(base + 5 + 4*i), 16'(base + 6 + 4*i),
                                             16'(base + 7 + 4*i), 16'(base + 8 + 4*i));
            end else begin
                r = int'($urandom_range(0, 2));
                tag = (r == 2) ? 2'd3 : 2'(r);
                heap[base + 1 + i] = mk_leaf(tag, {$urandom, $urandom});
            end
            for (int j = 0; j < 4; j++) begin
                r = int'($urandom_range(0, 2));
                tag = (r == 2) ? 2'd3 : 2'(r);
                heap[base + 5 + 4*i + j] = mk_leaf(tag, {$urandom, $urandom});
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) heap[i] = 67'd1;
        aresetn_a = 1'b0; aresetn_b = 1'b0;
        root_a = 17'd0; root_b = 17'd0;
        tready_a = 1'b0; tready_b = 1'b0;
        tmode_a = 1'b0; rnd_a = 1'b0; tmode_b = 1'b0; rnd_b = 1'b0;
        model_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_root_r", root_r_a, 67'd0);
        check("rst_rd_req", req_a, 67'd0);
        check("rst_rd_resp_r", resp_r_a, 67'd0);
        check("rst_tvalid", tvalid_a, 67'd0);
        check("rst_tlast", tlast_a, 67'd0);
        check("rst_tdata", tdata_a, 67'd0);
        check("rst_overflow", ovf_a, 67'd0);
        aresetn_a = 1'b1; aresetn_b = 1'b1;
        @(posedge clk); #2;
        check("root_r_after_reset", root_r_a, 67'd1);

        // single leaf, zero latency: exact cycle positions
        heap[5] = mk_val(32'h2A);
        expect_tree(1'b0, 5, 16);
        check("pin_leaf_word", mq[0].d, 67'h153);
        check("pin_leaf_count", mq.size(), 67'd1);
        send_root(1'b0, 5);
        check("leaf_req", req_a, 67'h0B);
        @(posedge clk); #2;
        check("leaf_wait_resp_r", resp_r_a, 67'd1);
        @(posedge clk); #2;
        check("leaf_emit_tvalid", tvalid_a, 67'd1);
        check("leaf_emit_tlast", tlast_a, 67'd1);
        wait_done(1'b0);

        // one node with four QVal children
        heap[1] = mk_node(16'd2, 16'd3, 16'd4, 16'd5);
        for (int i = 0; i < 4; i++) heap[2 + i] = mk_val(32'(i + 1));
        expect_tree(1'b0, 1, 16);
        check("pin_node_count", mq.size(), 67'd5);
        check("pin_node_first", mq[0].d, 67'hB);
        check("pin_node_first_last", mq[0].l, 67'd0);
        check("pin_node_word", mq[4].d, 67'h5);
        check("pin_node_last", mq[4].l, 67'd1);
        send_root(1'b0, 1);
        wait_done(1'b0);

        // depth-3 random trees, tready toggling, random heap latency
        tmode_a = 1'b1; rnd_a = 1'b1;
        for (int t = 0; t < 5; t++) begin
            build_random_tree(16);
            expect_tree(1'b0, 16, 16);
            send_root(1'b0, 16);
            wait_done(1'b0);
        end
        tmode_a = 1'b0;

        // back-to-back roots
        heap[40] = mk_leaf(TAG_QNONE, 64'd0);
        heap[41] = mk_node(16'd42, 16'd43, 16'd44, 16'd45);
        for (int i = 0; i < 4; i++) heap[42 + i] = 67'h7;
        expect_tree(1'b0, 40, 16);
        expect_tree(1'b0, 41, 16);
        check("pin_b2b_count", mq.size(), 67'd5);
        send_root(1'b0, 40);
        send_root(1'b0, 41);
        wait_done(1'b0);
        check("a_no_overflow", ovf_a, 67'd0);

        // depth-3 chain into a 2-deep stack
        rnd_b = 1'b1; tmode_b = 1'b1;
        heap[60] = mk_node(16'd61, 16'd70, 16'd71, 16'd72);
        heap[61] = mk_node(16'd62, 16'd73, 16'd74, 16'd75);
        heap[62] = mk_node(16'd76, 16'd77, 16'd78, 16'd79);
        for (int i = 70; i < 80; i++) heap[i] = mk_val(32'(i));
        model_ovf = 1'b0;
        expect_tree(1'b1, 60, 2);
        check("pin_ovf_count", mq.size(), 67'd9);
        check("pin_ovf_first", mq[0].d, 67'h7);
        check("pin_ovf_flag", model_ovf, 67'd1);
        send_root(1'b1, 60);
        wait_done(1'b1);
        check("b_overflow_set", ovf_b, 67'd1);
        heap[80] = mk_val(32'hDEAD_BEEF);
        expect_tree(1'b1, 80, 2);
        send_root(1'b1, 80);
        wait_done(1'b1);
        check("b_overflow_sticky", ovf_b, 67'd1);

        // reset in the middle of a traversal
        expect_tree(1'b1, 60, 2);
        send_root(1'b1, 60);
        repeat (7) @(posedge clk);
        #2;
        aresetn_b = 1'b0;
        @(posedge clk); #2;
        check("midrst_tvalid", tvalid_b, 67'd0);
        check("midrst_rd_req", req_b, 67'd0);
        check("midrst_overflow", ovf_b, 67'd0);
        aresetn_b = 1'b1;
        exp_b.delete();
        @(posedge clk); #2;
        expect_tree(1'b1, 1, 2);
        send_root(1'b1, 1);
        wait_done(1'b1);
        check("post_rst_overflow", ovf_b, 67'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/qtree_int_serializer.md
# qtree_int_serializer

Streams QTree_Int structures out of the heap as AXI-stream words, in the same postfix word format that the stream-to-heap loader consumes. Given a root pointer, it walks the tree depth-first through a heap read port and emits every node after its four children, asserting tlast on the root word. It sits on the result side of a mapped kernel: the kernel's output pointer goes in, and the host-facing stream comes out.

## Interface
- STACK_DEPTH, 16: maximum tree depth held in the traversal stack, root included.
- clk  in  1  clock.
- aresetn  in  1  reset; one clock; reset is synchronous and active-low.
- root_d  in  Pointer_QTree_Int_t (17)  tree to serialize; bit0 = valid, [16:1] = address.
- root_r  out  1  root accepted.
- rd_req_d  out  Pointer_QTree_Int_t (17)  heap read request; bit0 = valid.
- rd_req_r  in  1  heap accepts the request.
- rd_resp_d  in  QTree_Int_t (67)  heap read data; bit0 = valid.
- rd_resp_r  out  1  response consumed.
- o_QTree_Int_tdata  out  QTree_Int_t (67)  stream word.
- o_QTree_Int_tvalid / o_QTree_Int_tready  out/in  1  AXI-stream handshake.
- o_QTree_Int_tlast  out  1  set on the root word of each tree.
- overflow  out  1  sticky: depth exceeded since reset.

## Operation
- QTree_Int_t word layout:
  - [0] valid.
  - [2:1] tag: 0 QNone, 1 QVal, 2 QNode, 3 QError.
  - QVal: Int in [34:3].
  - QNode: child addresses q1 [18:3], q2 [34:19], q3 [50:35], q4 [66:51].
- Emitted words always have bit0 = 1.
  - QNode words are emitted with all child fields zeroed.
  - Leaf words are emitted exactly as read.
- Order is postfix: q1 subtree, q2, q3, q4, then the node itself.
- Traversal stack: STACK_DEPTH frames of {node word, child index 0..4}, plus stack pointer sp.
- FSM:
  - IDLE: root_r = 1. Accept root_d when bit0 = 1, latch its address, go to FETCH.
  - FETCH: drive rd_req_d = {addr, 1}. On rd_req_r, go to WAIT.
  - WAIT: rd_resp_r = 1. On rd_resp_d bit0:
    - QNode: push frame {word, 0}, go to NEXT.
    - Otherwise: load the word into the output register, go to EMIT.
  - NEXT: look at the top frame.
    - Index < 4: take child address q[index+1], increment index, go to FETCH.
    - Index == 4: load the zeroed node word, pop the frame, go to EMIT.
  - EMIT: hold tvalid until tready. tlast = 1 iff sp == 0, i.e. this is the root word.
    - After the handshake: go to IDLE if sp == 0, else NEXT.
- Overflow: a QNode read while sp == STACK_DEPTH is not pushed.
  - Instead a QError word (tag 3, payload 0) is emitted in its place and overflow is set.
  - The stream stays well-formed.
- Reset mid-tree: the stack is discarded and all outputs take reset values. The partial tree is not resumed.

## Timing
- Reset values:
  - root_r 0; rd_req_d 0; rd_resp_r 0.
  - tvalid 0; tlast 0; tdata 0; overflow 0.
  - FSM in IDLE, sp 0.
  - root_r rises the first cycle after reset is released.
- All outputs are registered.
- Root accept to first rd_req_d valid: 1 cycle.
- rd_resp_d may arrive any cycle after the request handshake, including the next one.
- The heap has at most one outstanding request.
- Minimum cost with zero heap latency and tready held high:
  - Leaf: FETCH, WAIT and EMIT, 3 cycles.
  - QNode: FETCH, WAIT, 5×NEXT and EMIT, excluding children.
- tdata and tlast are stable while tvalid = 1 and tready = 0.
- The next root is accepted no earlier than the cycle after the root word handshake.

## Structure
- mMaskKron_package holds QTree_Int_t, Pointer_QTree_Int_t, Int_t, the tag constants, and QNode_Int_dc/Pointer_QTree_Int_dc.
  - Add a frame typedef and a QTree_Int_node_strip function (zero the child fields) to it.
- Sub-module qtree_int_frame_stack: synchronous LIFO with push, pop, top, sp, full and empty. It holds no FSM logic.

## Test plan
- Single leaf: QVal 0x0000_002A at address 5, root {5,1} → one word, tag 1, [34:3] = 0x2A, tlast = 1.
- One node at address 1 with children 2,3,4,5, all QVal 1..4 → five words (vals 1,2,3,4, then tag 2 with zero children); tlast only on the 5th.
- Depth-3 tree with tready toggling 1/0 every cycle and heap latency 0..3 random → stream identical to the reference postfix list; tdata holds steady while stalled.
- Back-to-back roots A (leaf QNone) and B (node of 4 QError) → 1 + 5 words, tlast on words 1 and 6.
- STACK_DEPTH = 2 with a depth-3 chain → innermost QNode replaced by a QError word; overflow = 1 and stays 1; the stream is still postfix-complete with the correct tlast.
- aresetn pulsed low mid-traversal → next cycle tvalid = 0, rd_req_d = 0, overflow = 0; a fresh root then serializes correctly.
